// File: rtl/seq_div_if.sv
// Request/result bundle for the iterative divider: start with operands in,
// status and registered results out.
interface seq_div_if #(
  parameter int DATAWIDTH = 8
);
  logic                 start;
  logic [DATAWIDTH-1:0] A;
  logic [DATAWIDTH-1:0] B;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] Quot;
  logic [DATAWIDTH-1:0] Rem;
  logic                 div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Quot, Rem, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Quot, Rem, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Restoring unsigned divider producing one quotient bit per clock; a zero
// divisor bypasses the iteration and reports a saturated quotient one edge later.
module seq_div #(
  parameter int DATAWIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_div_if.slave  bus
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZDIV,
    DONE
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   dividend, dividend_next;
  logic [W-1:0]   divisor, divisor_next;
  logic [W-1:0]   prem, prem_next;
  logic [CW-1:0]  count, count_next;
  logic [W-1:0]   quot, quot_next;
  logic [W-1:0]   rem, rem_next;
  logic           dbz, dbz_next;

  logic [W:0]     trial;
  logic           fits;
  logic [W-1:0]   diff_lo;
  logic [W-1:0]   step_rem;
  logic [W-1:0]   step_dividend;
  logic           accept;

  // The guard bit lives in trial; a kept difference is always below the
  // divisor, so only its low W bits need computing.
  always_comb begin
    trial         = {prem, dividend[W-1]};
    fits          = (trial >= {1'b0, divisor});
    diff_lo       = trial[W-1:0] - divisor;
    step_rem      = fits ? diff_lo : trial[W-1:0];
    step_dividend = {dividend[W-2:0], fits};
    accept        = bus.start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_next    = state;
    dividend_next = dividend;
    divisor_next  = divisor;
    prem_next     = prem;
    count_next    = count;
    quot_next     = quot;
    rem_next      = rem;
    dbz_next      = dbz;

    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept) begin
          dividend_next = bus.A;
          divisor_next  = bus.B;
          prem_next     = '0;
          count_next    = '0;
          if (bus.B == '0) begin
            state_next = ZDIV;
          end else begin
            state_next = RUN;
            dbz_next   = 1'b0;
          end
        end
      end

      RUN: begin
        dividend_next = step_dividend;
        prem_next     = step_rem;
        count_next    = count + 1'b1;
        if (count == CW'(W - 1)) begin
          quot_next  = step_dividend;
          rem_next   = step_rem;
          state_next = DONE;
        end
      end

      ZDIV: begin
        quot_next  = '1;
        rem_next   = dividend;
        dbz_next   = 1'b1;
        state_next = DONE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dividend <= '0;
      divisor  <= '0;
      prem     <= '0;
      count    <= '0;
      quot     <= '0;
      rem      <= '0;
      dbz      <= 1'b0;
    end else begin
      state    <= state_next;
      dividend <= dividend_next;
      divisor  <= divisor_next;
      prem     <= prem_next;
      count    <= count_next;
      quot     <= quot_next;
      rem      <= rem_next;
      dbz      <= dbz_next;
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.Quot        = quot;
  assign bus.Rem         = rem;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div.sv
// Randomized and directed checks of seq_div against a cycle-level arithmetic
// model of when results appear and what they must be.
module tb_seq_div;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  int   accepted;
  int   completed;
  int   pend_a;
  int   pend_b;
  int   pend_t;
  int   held_q;
  int   held_r;
  int   held_z;
  int   last_done;

  seq_div_if #(.DATAWIDTH(W)) bus ();

  seq_div #(.DATAWIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // A request accepted at edge t finishes at edge t+W, or t+1 for a zero divisor.
  task automatic check_output();
    bit exp_done;
    bit exp_busy;
    bit pending;
    exp_done = 1'b0;
    exp_busy = 1'b0;
    if (!rst) begin
      completed = accepted;
      held_q    = 0;
      held_r    = 0;
      held_z    = 0;
    end else begin
      pending  = (accepted != completed);
      exp_done = pending && (cyc == pend_t + ((pend_b == 0) ? 1 : W));
      exp_busy = pending && (pend_b != 0) && (cyc >= pend_t) && (cyc < pend_t + W);
      if (exp_done) begin
        held_q    = (pend_b == 0) ? 255 : pend_a / pend_b;
        held_r    = (pend_b == 0) ? pend_a : pend_a % pend_b;
        held_z    = (pend_b == 0) ? 1 : 0;
        completed = completed + 1;
        last_done = cyc;
      end else if (pending && (pend_b != 0) && (cyc >= pend_t)) begin
        held_z = 0;
      end
    end
    check_val("done", int'(bus.done), int'(exp_done));
    check_val("busy", int'(bus.busy), int'(exp_busy));
    check_val("quot", int'(bus.Quot), held_q);
    check_val("rem", int'(bus.Rem), held_r);
    check_val("div_by_zero", int'(bus.div_by_zero), held_z);
    check_val("busy_and_done", int'(bus.busy & bus.done), 0);
  endtask

  task automatic tick();
    @(negedge clk);
    check_output();
    #1;
  endtask

  task automatic apply_stimulus(input int a, input int b, output bit acc, output int t);
    bus.start = 1'b1;
    bus.A     = W'(a);
    bus.B     = W'(b);
    acc       = (accepted == completed);
    t         = cyc + 1;
    if (acc) begin
      pend_a   = a;
      pend_b   = b;
      pend_t   = t;
      accepted = accepted + 1;
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((accepted != completed) && (n < budget)) begin
      tick();
      n++;
    end
    check_val("drained", int'(accepted != completed), 0);
  endtask

  task automatic check_result(input string name, input int q, input int r, input int z,
                              input int t, input int lat);
    check_val({name, "_quot"}, int'(bus.Quot), q);
    check_val({name, "_rem"}, int'(bus.Rem), r);
    check_val({name, "_dbz"}, int'(bus.div_by_zero), z);
    check_val({name, "_latency"}, last_done - t, lat);
  endtask

  initial begin
    bit acc;
    int t;
    int t2;
    int edge_a[3];
    int edge_b[3];
    int edge_q[3];
    int edge_r[3];
    tests     = 0;
    fails     = 0;
    accepted  = 0;
    completed = 0;
    pend_a    = 0;
    pend_b    = 0;
    pend_t    = 0;
    held_q    = 0;
    held_r    = 0;
    held_z    = 0;
    last_done = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    repeat (2) tick();
    check_val("reset_quot", int'(bus.Quot), 0);
    check_val("reset_busy", int'(bus.busy), 0);
    rst = 1'b1;

    apply_stimulus(100, 7, acc, t);
    check_val("accept_100_7", int'(acc), 1);
    wait_done(20);
    check_result("div_100_7", 14, 2, 0, t, 8);

    edge_a = '{255, 5, 255};
    edge_b = '{1, 9, 255};
    edge_q = '{255, 0, 1};
    edge_r = '{0, 5, 0};
    for (int i = 0; i < 3; i++) begin
      tick();
      apply_stimulus(edge_a[i], edge_b[i], acc, t);
      wait_done(20);
      check_result("edge", edge_q[i], edge_r[i], 0, t, 8);
    end

    tick();
    apply_stimulus(42, 0, acc, t);
    wait_done(20);
    check_result("div_zero", 255, 42, 1, t, 1);
    apply_stimulus(9, 3, acc, t);
    check_val("accept_after_zero", int'(acc), 1);
    wait_done(20);
    check_result("div_9_3", 3, 0, 0, t, 8);

    tick();
    apply_stimulus(100, 7, acc, t);
    tick();
    tick();
    apply_stimulus(50, 5, acc, t2);
    check_val("ignored_start", int'(acc), 0);
    wait_done(20);
    check_result("ignored", 14, 2, 0, t, 8);

    apply_stimulus(200, 10, acc, t);
    check_val("back_to_back_accept", int'(acc), 1);
    wait_done(20);
    check_result("back_to_back", 20, 0, 0, t, 8);

    tick();
    apply_stimulus(100, 7, acc, t);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_val("midreset_quot", int'(bus.Quot), 0);
    check_val("midreset_rem", int'(bus.Rem), 0);
    check_val("midreset_busy", int'(bus.busy), 0);
    check_val("midreset_done", int'(bus.done), 0);
    repeat (2) tick();
    rst = 1'b1;
    apply_stimulus(17, 4, acc, t);
    check_val("accept_after_reset", int'(acc), 1);
    wait_done(20);
    check_result("div_17_4", 4, 1, 0, t, 8);

    for (int i = 0; i < 1000; i++) begin
      int gap;
      apply_stimulus(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), acc, t);
      check_val("rand_accept", int'(acc), 1);
      wait_done(20);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Iterative, multi-cycle unsigned divider for the datapath component library. It is the inverse-direction companion to the combinational multiplier. It computes quotient and remainder by restoring division, one quotient bit per clock, so wide divides stay off the critical path. It is driven by a single-cycle `start` pulse and reports completion with a single-cycle `done` pulse, for use by schedulers and FSM-controlled datapaths.

## Interface
- `DATAWIDTH`, default 8: operand and result width in bits; must be ≥ 2.

- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled on a rising edge only while `busy`=0.
- `A`  input  DATAWIDTH  dividend, unsigned; sampled with `start`.
- `B`  input  DATAWIDTH  divisor, unsigned; sampled with `start`.
- `busy`  output  1  high while a division is in progress.
- `done`  output  1  one-cycle pulse; results are valid.
- `Quot`  output  DATAWIDTH  quotient, registered.
- `Rem`  output  DATAWIDTH  remainder, registered.
- `div_by_zero`  output  1  set when the last accepted `B` was 0.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset (`rst`=0):** takes effect immediately, without waiting for a clock edge.
  - State goes to IDLE.
  - `busy`, `done`, `Quot`, `Rem`, `div_by_zero` are all 0.
  - Internal counter and working registers are cleared.
- **Accepting a request:** `start`=1 is accepted in IDLE or DONE, i.e. whenever `busy`=0.
  - `A` and `B` are latched into internal registers.
  - `div_by_zero` is cleared unless the new `B` is 0.
  - `start` during RUN is ignored; the operation in progress and the latched operands are unaffected.
- **IDLE/DONE, `start`=1, B≠0:**
  - Load dividend shift register = A.
  - Load partial remainder = 0 (DATAWIDTH+1 bits).
  - Load iteration counter = 0.
  - Go to RUN.
- **IDLE/DONE, `start`=1, B=0:** go directly to DONE with
  - `Quot` = all ones,
  - `Rem` = A,
  - `div_by_zero` = 1.
- **RUN, each cycle (one restoring step):**
  - Shift the dividend MSB into the partial remainder.
  - Trial-subtract B.
  - If the difference is non-negative (no borrow), keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments. After DATAWIDTH steps, write `Quot`/`Rem` and go to DONE.
- **DONE:** lasts one cycle, then returns to IDLE unless `start`=1 is accepted (back-to-back operation).
- **Output holding:** `Quot`, `Rem` and `div_by_zero` hold their values until the next result is written or reset occurs. They do not change during RUN.
- **Arithmetic:** unsigned throughout. Results always satisfy Quot·B + Rem = A and Rem < B. The partial remainder uses 1 guard bit, so no overflow is possible.

## Timing
- Let T be the rising edge that accepts `start`.
- **Normal divide:**
  - `busy`=1 from edge T to edge T+DATAWIDTH.
  - Results are written and `done`=1 at edge T+DATAWIDTH.
  - `done` clears at edge T+DATAWIDTH+1.
  - Latency: DATAWIDTH edges from acceptance to `done`.
- **Divide by zero:**
  - `done`=1 and results are written at edge T+1.
  - `busy` is never asserted.
- **Throughput:** with back-to-back `start` during DONE, one result every DATAWIDTH+1 cycles.
- **Reset mid-RUN:** aborts the operation. No `done` is produced and the previous results are lost (outputs read 0).
- **Reset release:** first `start` is accepted on the first rising edge with `rst`=1.
- `done` and `busy` are never high in the same cycle.

## Test plan
All scenarios use DATAWIDTH=8.
- **Normal divide:** A=100, B=7, `start` at edge T → `busy` for 8 cycles; `done` at T+8; Quot=14, Rem=2, `div_by_zero`=0.
- **Edge operands:**
  - A=255, B=1 → Quot=255, Rem=0.
  - A=5, B=9 → Quot=0, Rem=5.
  - A=255, B=255 → Quot=1, Rem=0.
- **Divide by zero:** A=42, B=0 → `done` at T+1; Quot=255, Rem=42, `div_by_zero`=1, `busy` stays 0. A following A=9, B=3 → Quot=3, Rem=0, `div_by_zero`=0.
- **Ignored start:** after starting A=100, B=7, pulse `start` with A=50, B=5 at T+3 → the request is ignored; the result is still 14 r 2 at T+8.
- **Back-to-back:** `start` with A=200, B=10 during the DONE cycle of the prior operation → accepted; `done` 8 edges later with Quot=20, Rem=0.
- **Reset mid-operation:** assert `rst`=0 at T+4 → all outputs 0 immediately, no `done`. Release reset, then start A=17, B=4 → Quot=4, Rem=1.
- **Randomized check:** 1000 random (A, B≠0) pairs checked against A/B and A%B.
